// File: rtl/hamming_pkg.sv
// Shared types and helpers for the SECDED decode engine.
// Codeword bit k (1..15) is Hamming position k; bit 0 is overall parity.
package hamming_pkg;

    localparam int CW_W   = 16;
    localparam int DATA_W = 11;

    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 2;
    localparam int P4_POS = 4;
    localparam int P8_POS = 8;

    typedef enum logic [1:0] {
        FLG_OK  = 2'b00,
        FLG_COR = 2'b01,
        FLG_DBL = 2'b10
    } flag_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_CAP,
        S_DEC,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } dec_state_t;

    function automatic logic [3:0] hamming_syndrome(input logic [CW_W-1:0] cw);
        logic [3:0] s;
        s = '0;
        for (int k = 1; k < CW_W; k++) begin
            if (cw[k]) s = s ^ 4'(k);
        end
        return s;
    endfunction

endpackage

// File: rtl/secded_dec16.sv
// Combinational SECDED decode of one 16-bit codeword into 11 data bits and a status flag.
module secded_dec16
    import hamming_pkg::*;
(
    input  logic [CW_W-1:0]   i_cw,
    output logic [DATA_W:1]   o_data,
    output flag_t             o_flag
);

    logic [3:0]      w_syn;
    logic            w_par;
    logic [CW_W-1:0] w_fix;

    always_comb begin
        w_syn  = hamming_syndrome(i_cw);
        w_par  = ^i_cw;
        w_fix  = i_cw;
        o_flag = FLG_OK;
        // Odd overall parity means one flip; syndrome 0 points at p0 itself.
        if (w_par) begin
            w_fix[w_syn] = ~i_cw[w_syn];
            o_flag       = FLG_COR;
        end else if (w_syn != 4'd0) begin
            o_flag = FLG_DBL;
        end
        o_data = {w_fix[15:9], w_fix[7:5], w_fix[3]};
    end

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-walking SECDED decoder: reads NUM_MSG codewords, writes data+status back.
// Fixed 6-cycle schedule per message over a sync-read byte memory.
module hamming_dec_engine
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int IN_BASE  = 30,
    parameter int OUT_BASE = 0
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_mem_rdata,
    output logic [7:0] o_mem_addr,
    output logic       o_mem_wen,
    output logic [7:0] o_mem_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_err1_cnt,
    output logic [3:0] o_err2_cnt
);

    dec_state_t        r_state, w_next;
    logic [6:0]        r_idx;
    logic [7:0]        r_lo, r_hi;
    logic [DATA_W:1]   r_data;
    flag_t             r_flag;
    logic [3:0]        r_err1, r_err2;
    logic              r_done;

    logic [DATA_W:1]   w_dec_data;
    flag_t             w_dec_flag;
    logic              w_go, w_last;
    logic [7:0]        w_in_addr, w_out_addr;

    secded_dec16 u_dec (
        .i_cw   ({r_hi, r_lo}),
        .o_data (w_dec_data),
        .o_flag (w_dec_flag)
    );

    assign w_go       = i_start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last     = (r_idx == 7'(NUM_MSG - 1));
    // 8-bit sums wrap modulo 256 by construction.
    assign w_in_addr  = 8'(IN_BASE)  + {r_idx, 1'b0};
    assign w_out_addr = 8'(OUT_BASE) + {r_idx, 1'b0};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        o_mem_addr  = 8'd0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = 8'd0;
        o_busy      = 1'b0;
        case (r_state)
            S_IDLE:  if (w_go) w_next = S_RD_LO;
            S_RD_LO: begin
                o_busy     = 1'b1;
                o_mem_addr = w_in_addr;
                w_next     = S_RD_HI;
            end
            S_RD_HI: begin
                o_busy     = 1'b1;
                o_mem_addr = w_in_addr + 8'd1;
                w_next     = S_CAP;
            end
            S_CAP: begin
                o_busy = 1'b1;
                w_next = S_DEC;
            end
            S_DEC: begin
                o_busy = 1'b1;
                w_next = S_WR_LO;
            end
            S_WR_LO: begin
                o_busy      = 1'b1;
                o_mem_wen   = 1'b1;
                o_mem_addr  = w_out_addr;
                o_mem_wdata = r_data[8:1];
                w_next      = S_WR_HI;
            end
            S_WR_HI: begin
                o_busy      = 1'b1;
                o_mem_wen   = 1'b1;
                o_mem_addr  = w_out_addr + 8'd1;
                o_mem_wdata = {r_flag, 3'b000, r_data[11:9]};
                w_next      = w_last ? S_DONE : S_RD_LO;
            end
            S_DONE:  if (w_go) w_next = S_RD_LO;
            default: w_next = S_IDLE;
        endcase
    end

    // Read data lands one cycle after its address, so each byte is captured a state later.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_idx  <= '0;
            r_lo   <= '0;
            r_hi   <= '0;
            r_data <= '0;
            r_flag <= FLG_OK;
            r_err1 <= '0;
            r_err2 <= '0;
            r_done <= 1'b0;
        end else if (w_go) begin
            r_idx  <= '0;
            r_err1 <= '0;
            r_err2 <= '0;
            r_done <= 1'b0;
        end else begin
            case (r_state)
                S_RD_HI: r_lo <= i_mem_rdata;
                S_CAP:   r_hi <= i_mem_rdata;
                S_DEC: begin
                    r_data <= w_dec_data;
                    r_flag <= w_dec_flag;
                    if (w_dec_flag == FLG_COR && r_err1 != 4'hF) r_err1 <= r_err1 + 4'd1;
                    if (w_dec_flag == FLG_DBL && r_err2 != 4'hF) r_err2 <= r_err2 + 4'd1;
                end
                S_WR_HI: if (!w_last) r_idx <= r_idx + 7'd1;
                S_DONE:  r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign o_done     = r_done;
    assign o_err1_cnt = r_err1;
    assign o_err2_cnt = r_err2;

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Scoreboard bench for hamming_dec_engine: random encoded words with injected flips,
// expected writes queued at stimulus time and checked by an independent write monitor.
module tb_hamming_dec_engine;

    localparam int NUM_MSG  = 15;
    localparam int IN_BASE  = 30;
    localparam int OUT_BASE = 0;
    localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rdata, addr, wdata;
    logic       wen, busy, done;
    logic [3:0] e1, e2;

    logic [7:0] mem [256];
    logic       tb_we = 1'b0;
    logic [7:0] tb_a = 8'd0, tb_d = 8'd0;

    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t sbq[$];

    int checks = 0, errors = 0;
    logic [7:0] exp_lo [NUM_MSG];
    logic [7:0] exp_hi [NUM_MSG];
    int x1, x2;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rdata <= mem[addr];
        if (wen)        mem[addr] <= wdata;
        else if (tb_we) mem[tb_a] <= tb_d;
    end

    hamming_dec_engine #(.NUM_MSG(NUM_MSG), .IN_BASE(IN_BASE), .OUT_BASE(OUT_BASE)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_mem_rdata (rdata),
        .o_mem_addr  (addr),
        .o_mem_wen   (wen),
        .o_mem_wdata (wdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_err1_cnt  (e1),
        .o_err2_cnt  (e2)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
        end
    endtask

    // Monitor: every write the DUT makes must be the next one the scoreboard expects.
    always @(negedge clk) begin
        wr_t e;
        if (wen === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0h:%0h expected=none", addr, wdata);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", 32'(addr), 32'(e.a));
                chk("wr_data", 32'(wdata), 32'(e.d));
            end
        end
    end

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        logic        par;
        w = '0;
        for (int j = 0; j < 11; j++) w[DPOS[j]] = d[j];
        for (int p = 0; p < 4; p++) begin
            par = 1'b0;
            for (int k = 1; k < 16; k++) if (((k >> p) & 1) == 1) par = par ^ w[k];
            w[1 << p] = par;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] w);
        logic [10:0] d;
        for (int j = 0; j < 11; j++) d[j] = w[DPOS[j]];
        return d;
    endfunction

    task automatic wb(input logic [7:0] a, input logic [7:0] d);
        tb_we = 1'b1;
        tb_a  = a;
        tb_d  = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    // Build a run: the result depends only on how many bits were flipped.
    task automatic prepare_run(input bit directed);
        logic [10:0] d, dx;
        logic [15:0] m, cw;
        int nf, a, b;
        x1 = 0;
        x2 = 0;
        for (int i = 0; i < NUM_MSG; i++) begin
            d  = 11'($urandom_range(0, 2047));
            nf = $urandom_range(0, 2);
            a  = $urandom_range(0, 15);
            b  = (a + 1 + $urandom_range(0, 14)) % 16;
            m  = (nf == 0) ? 16'h0 : (nf == 1) ? (16'h1 << a) : ((16'h1 << a) | (16'h1 << b));
            if (directed && i < 4) begin
                d = 11'h001;
                case (i)
                    0:       m = 16'h0000;
                    1:       m = 16'h0200;
                    2:       m = 16'h0001;
                    default: m = 16'h0600;
                endcase
                nf = $countones(m);
            end
            cw = encode(d) ^ m;
            dx = (nf == 2) ? extract(cw) : d;
            exp_lo[i] = dx[7:0];
            exp_hi[i] = {2'(nf), 3'b000, dx[10:8]};
            if (nf == 1 && x1 < 15) x1++;
            if (nf == 2 && x2 < 15) x2++;
            wb(8'(IN_BASE + 2 * i), cw[7:0]);
            wb(8'(IN_BASE + 2 * i + 1), cw[15:8]);
            sbq.push_back('{a: 8'(OUT_BASE + 2 * i), d: exp_lo[i]});
            sbq.push_back('{a: 8'(OUT_BASE + 2 * i + 1), d: exp_hi[i]});
        end
    endtask

    task automatic run(input bit pulse40, output int cyc);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
            start = (pulse40 && cyc == 39);
            if (cyc == 1)             chk("done_cleared", 32'(done), 0);
            if (pulse40 && cyc == 40) chk("busy_after_ignored_start", 32'(busy), 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, 32'(addr), 0);
        chk({tag, "_wen"},  32'(wen), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_err1"}, 32'(e1), 0);
        chk({tag, "_err2"}, 32'(e2), 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Run A: four directed words then random ones; start pulse while busy.
        prepare_run(1'b1);
        run(1'b1, cyc);
        chk("runA_done_latency", 32'(cyc), 91);
        chk("runA_err1", 32'(e1), 32'(x1));
        chk("runA_err2", 32'(e2), 32'(x2));
        chk("runA_sb_empty", 32'(sbq.size()), 0);
        chk("runA_busy_in_done", 32'(busy), 0);
        chk("t1_lo", 32'(mem[OUT_BASE + 0]), 32'h01);
        chk("t1_hi", 32'(mem[OUT_BASE + 1]), 32'h00);
        chk("t2_lo", 32'(mem[OUT_BASE + 2]), 32'h01);
        chk("t2_hi", 32'(mem[OUT_BASE + 3]), 32'h40);
        chk("t3_lo", 32'(mem[OUT_BASE + 4]), 32'h01);
        chk("t3_hi", 32'(mem[OUT_BASE + 5]), 32'h40);
        chk("t4_lo", 32'(mem[OUT_BASE + 6]), 32'h31);
        chk("t4_hi", 32'(mem[OUT_BASE + 7]), 32'h80);

        // Run B: reset mid-run; earlier writes survive, later slots untouched.
        for (int i = 0; i < 2 * NUM_MSG; i++) wb(8'(OUT_BASE + i), 8'hEE);
        prepare_run(1'b0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        chk("midrun_pending_writes", 32'(sbq.size()), 32'(2 * NUM_MSG - 6));
        sbq.delete();
        repeat (3) @(posedge clk);
        for (int i = 0; i < NUM_MSG; i++) begin
            chk("runB_mem_lo", 32'(mem[OUT_BASE + 2 * i]),     (i < 3) ? 32'(exp_lo[i]) : 32'hEE);
            chk("runB_mem_hi", 32'(mem[OUT_BASE + 2 * i + 1]), (i < 3) ? 32'(exp_hi[i]) : 32'hEE);
        end
        @(negedge clk) rst_n = 1'b1;

        // Run C: fresh run after reset starts from message 0 with clear counters.
        prepare_run(1'b0);
        run(1'b0, cyc);
        chk("runC_done_latency", 32'(cyc), 91);
        chk("runC_err1", 32'(e1), 32'(x1));
        chk("runC_err2", 32'(e2), 32'(x2));
        chk("runC_sb_empty", 32'(sbq.size()), 0);
        for (int i = 0; i < NUM_MSG; i++) begin
            chk("runC_mem_lo", 32'(mem[OUT_BASE + 2 * i]),     32'(exp_lo[i]));
            chk("runC_mem_hi", 32'(mem[OUT_BASE + 2 * i + 1]), 32'(exp_hi[i]));
        end
        repeat (3) @(posedge clk);
        chk("done_held", 32'(done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
